// File: rtl/pc_log_pkg.sv
// pc_log_pkg
// Shared types and default widths for the protocol-checker status logger.
//   LOG_STATUS_W : default width of the checker status vector
//   LOG_TS_W     : default width of the free-running timestamp
//   pc_event_t   : one logged violation event (status vector plus timestamp)
//   log_state_e  : logger state (CLEAN, LOGGING, OVERFLOWED)
package pc_log_pkg;

  localparam int LOG_STATUS_W = 160;
  localparam int LOG_TS_W     = 32;

  // The event record that travels through the FIFO. The timestamp is the
  // value of the free-running counter in the cycle the event was detected.
  typedef struct packed {
    logic [LOG_STATUS_W-1:0] status;
    logic [LOG_TS_W-1:0]     timestamp;
  } pc_event_t;

  typedef enum logic [1:0] {
    CLEAN      = 2'd0,
    LOGGING    = 2'd1,
    OVERFLOWED = 2'd2
  } log_state_e;

endpackage

// File: rtl/pc_event_fifo.sv
// pc_event_fifo
// Synchronous first-word-fall-through FIFO of pc_event_t records.
//   clk, reset : clock and asynchronous active-high reset
//   flush      : synchronous flush, empties the FIFO (wins over push/pop)
//   push       : write wr_data; dropped when full unless a pop happens too
//   pop        : discard the head entry; ignored when empty
//   wr_data    : event to enqueue
//   rd_data    : head entry, forced to zero while empty
//   full/empty : occupancy flags
module pc_event_fifo
  import pc_log_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  pc_event_t wr_data,
  output pc_event_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  pc_event_t       mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_pop;
  logic            do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle, which is what gives one push and one pop per cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer update; flush simply re-aligns both pointers at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; stale contents are never visible because the
  // read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // First-word-fall-through read port.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pc_status_logger.sv
// pc_status_logger
// Timestamps and logs violation events reported by the AXI protocol checker.
//   clk, reset    : clock and asynchronous active-high reset
//   pc_status     : checker status vector
//   pc_asserted   : checker "any violation" flag
//   clear         : synchronous clear of FIFO, first/sticky/count and state
//   evt_rd        : pop the head event (ignored when evt_valid is low)
//   evt_valid     : event FIFO non-empty
//   evt_status    : head event status vector
//   evt_time      : head event timestamp
//   first_status  : status of the first event since reset/clear
//   first_time    : timestamp of the first event
//   sticky_status : OR of all event statuses since reset/clear
//   evt_count     : number of events detected, saturating
//   overflow      : an event was dropped because the FIFO was full
//   irq           : registered evt_valid | overflow
module pc_status_logger
  import pc_log_pkg::*;
#(
  parameter int STATUS_W = LOG_STATUS_W,
  parameter int DEPTH    = 8,
  parameter int TS_W     = LOG_TS_W,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [STATUS_W-1:0] pc_status,
  input  logic                pc_asserted,
  input  logic                clear,
  input  logic                evt_rd,
  output logic                evt_valid,
  output logic [STATUS_W-1:0] evt_status,
  output logic [TS_W-1:0]     evt_time,
  output logic [STATUS_W-1:0] first_status,
  output logic [TS_W-1:0]     first_time,
  output logic [STATUS_W-1:0] sticky_status,
  output logic [CNT_W-1:0]    evt_count,
  output logic                overflow,
  output logic                irq
);

  logic [TS_W-1:0]     ts_q;
  logic                asserted_q;
  logic [STATUS_W-1:0] status_q;
  logic [STATUS_W-1:0] first_status_q;
  logic [TS_W-1:0]     first_time_q;
  logic [STATUS_W-1:0] sticky_q;
  logic [CNT_W-1:0]    count_q;
  logic                irq_q;
  log_state_e          log_state;

  logic                event_det;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  pc_event_t           wr_event;
  pc_event_t           head_event;

  // A held violation is a single event; a new rising flag or any change of
  // the vector while the flag stays high counts as a fresh event.
  assign event_det = pc_asserted && (!asserted_q || (pc_status != status_q));
  assign fifo_pop  = evt_rd && !fifo_empty;

  assign wr_event.status    = pc_status;
  assign wr_event.timestamp = ts_q;

  pc_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (clear),
    .push    (event_det),
    .pop     (evt_rd),
    .wr_data (wr_event),
    .rd_data (head_event),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Free-running timestamp and one-cycle input history. Neither is touched
  // by clear, so a violation held across a clear is not logged again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q       <= '0;
      asserted_q <= 1'b0;
      status_q   <= '0;
    end else begin
      ts_q       <= ts_q + 1'b1;
      asserted_q <= pc_asserted;
      status_q   <= pc_status;
    end
  end

  // Logger state plus the first/sticky/count summary registers. Clear wins
  // over a same-cycle event, which is then discarded entirely. Events that
  // the FIFO drops still contribute to sticky and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      log_state      <= CLEAN;
      first_status_q <= '0;
      first_time_q   <= '0;
      sticky_q       <= '0;
      count_q        <= '0;
    end else if (clear) begin
      log_state      <= CLEAN;
      first_status_q <= '0;
      first_time_q   <= '0;
      sticky_q       <= '0;
      count_q        <= '0;
    end else if (event_det) begin
      sticky_q <= sticky_q | pc_status;
      if (count_q != {CNT_W{1'b1}}) count_q <= count_q + 1'b1;
      case (log_state)
        CLEAN: begin
          first_status_q <= pc_status;
          first_time_q   <= ts_q;
          log_state      <= (fifo_full && !fifo_pop) ? OVERFLOWED : LOGGING;
        end
        LOGGING: begin
          if (fifo_full && !fifo_pop) log_state <= OVERFLOWED;
        end
        OVERFLOWED: log_state <= OVERFLOWED;
        default:    log_state <= CLEAN;
      endcase
    end
  end

  // Interrupt is a registered copy of the status outputs, so it trails the
  // event by two cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= evt_valid | overflow;
  end

  assign evt_valid     = !fifo_empty;
  assign evt_status    = head_event.status;
  assign evt_time      = head_event.timestamp;
  assign first_status  = first_status_q;
  assign first_time    = first_time_q;
  assign sticky_status = sticky_q;
  assign evt_count     = count_q;
  assign overflow      = (log_state == OVERFLOWED);
  assign irq           = irq_q;

endmodule

// File: tb/tb_pc_status_logger.sv
// tb_pc_status_logger
// Self-checking bench for pc_status_logger. A queue-based reference model of
// the event log is advanced on every clock edge from the same stimulus the
// DUT sees; outputs are compared on the falling edge.
module tb_pc_status_logger;
  import pc_log_pkg::*;

  localparam int SW      = 160;
  localparam int TW      = 32;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic          clk;
  logic          reset;
  logic [SW-1:0] pc_status;
  logic          pc_asserted;
  logic          clear;
  logic          evt_rd;
  logic          evt_valid;
  logic [SW-1:0] evt_status;
  logic [TW-1:0] evt_time;
  logic [SW-1:0] first_status;
  logic [TW-1:0] first_time;
  logic [SW-1:0] sticky_status;
  logic [CNT_W-1:0] evt_count;
  logic          overflow;
  logic          irq;

  int checks;
  int failures;

  pc_status_logger #(
    .STATUS_W (SW),
    .DEPTH    (DEPTH),
    .TS_W     (TW),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_status     (pc_status),
    .pc_asserted   (pc_asserted),
    .clear         (clear),
    .evt_rd        (evt_rd),
    .evt_valid     (evt_valid),
    .evt_status    (evt_status),
    .evt_time      (evt_time),
    .first_status  (first_status),
    .first_time    (first_time),
    .sticky_status (sticky_status),
    .evt_count     (evt_count),
    .overflow      (overflow),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [SW-1:0] status;
    logic [TW-1:0] tstamp;
  } ev_t;

  ev_t           mq[$];
  logic [TW-1:0] m_ts;
  logic          m_prev_a;
  logic [SW-1:0] m_prev_s;
  logic [SW-1:0] m_sticky;
  logic [SW-1:0] m_first_s;
  logic [TW-1:0] m_first_t;
  bit            m_started;
  int            m_count;
  bit            m_ovf;
  bit            m_irq;

  function automatic logic [SW-1:0] bit_vec(input int idx);
    logic [SW-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [SW-1:0] rand_status();
    logic [SW-1:0] v;
    for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ts      = '0;
    m_prev_a  = 1'b0;
    m_prev_s  = '0;
    m_sticky  = '0;
    m_first_s = '0;
    m_first_t = '0;
    m_started = 0;
    m_count   = 0;
    m_ovf     = 0;
    m_irq     = 0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    pc_asserted = 1'b0;
    pc_status   = '0;
    clear       = 1'b0;
    evt_rd      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Drives one cycle of stimulus, advances the model at the rising edge and
  // returns on the following falling edge, ready for comparisons.
  task automatic apply_stimulus(input logic a, input logic [SW-1:0] s,
                                input logic clr, input logic rd);
    bit  ev;
    bit  old_valid;
    bit  old_ovf;
    ev_t e;
    pc_asserted = a;
    pc_status   = s;
    clear       = clr;
    evt_rd      = rd;
    @(posedge clk);
    old_valid = (mq.size() > 0);
    old_ovf   = m_ovf;
    ev = a && (!m_prev_a || (s != m_prev_s));
    if (clr) begin
      mq.delete();
      m_sticky  = '0;
      m_first_s = '0;
      m_first_t = '0;
      m_started = 0;
      m_count   = 0;
      m_ovf     = 0;
    end else begin
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (ev) begin
        if (mq.size() < DEPTH) begin
          e.status = s;
          e.tstamp = m_ts;
          mq.push_back(e);
        end else begin
          m_ovf = 1;
        end
        m_sticky = m_sticky | s;
        if (m_count < CNT_MAX) m_count++;
        if (!m_started) begin
          m_started = 1;
          m_first_s = s;
          m_first_t = m_ts;
        end
      end
    end
    m_irq    = old_valid | old_ovf;
    m_ts     = m_ts + 1;
    m_prev_a = a;
    m_prev_s = s;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (evt_valid !== 1'b0 || evt_count !== '0 || irq !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: valid=%b count=%0d irq=%b ovf=%b required all 0",
               evt_valid, evt_count, irq, overflow);
    end
    checks++;
    if (evt_status !== '0 || evt_time !== '0 || sticky_status !== '0 || first_time !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: status/time/sticky/first not zero");
    end
    repeat (20) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b0 || evt_count !== '0 || irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_20: valid=%b count=%0d irq=%b required 0 0 0",
               evt_valid, evt_count, irq);
    end
    checks++;
    if (dut.ts_q !== 32'd20) begin
      failures++;
      $display("[TB] FAIL idle_ts: got %0d required 20", dut.ts_q);
    end
  endtask

  task automatic test_held_event();
    do_reset();
    repeat (5) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b1, bit_vec(3), 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_time !== 32'd5 || first_time !== 32'd5 || evt_count !== 4'd1) begin
      failures++;
      $display("[TB] FAIL held_first: valid=%b time=%0d first_time=%0d count=%0d required 1 5 5 1",
               evt_valid, evt_time, first_time, evt_count);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL irq_early: got %b required 0", irq);
    end
    apply_stimulus(1'b1, bit_vec(3), 1'b0, 1'b0);
    checks++;
    if (irq !== 1'b1 || dut.ts_q !== 32'd7) begin
      failures++;
      $display("[TB] FAIL irq_ts7: irq=%b ts=%0d required 1 at ts 7", irq, dut.ts_q);
    end
    repeat (8) apply_stimulus(1'b1, bit_vec(3), 1'b0, 1'b0);
    checks++;
    if (evt_count !== 4'd1 || evt_time !== 32'd5 || evt_status !== bit_vec(3)) begin
      failures++;
      $display("[TB] FAIL held_single: count=%0d time=%0d required 1 5", evt_count, evt_time);
    end
  endtask

  task automatic test_status_change();
    // Continues from the held bit-3 violation of the previous test.
    apply_stimulus(1'b1, bit_vec(3) | bit_vec(7), 1'b0, 1'b0);
    apply_stimulus(1'b1, bit_vec(0), 1'b0, 1'b0);
    checks++;
    if (evt_count !== 4'd3) begin
      failures++;
      $display("[TB] FAIL change_count: got %0d required 3", evt_count);
    end
    checks++;
    if (sticky_status !== (bit_vec(0) | bit_vec(3) | bit_vec(7)) || first_status !== bit_vec(3)) begin
      failures++;
      $display("[TB] FAIL change_sticky: sticky=%h first=%h", sticky_status, first_status);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_status !== mq[0].status || evt_time !== mq[0].tstamp) begin
        failures++;
        $display("[TB] FAIL change_pop%0d: valid=%b time=%0d required time %0d",
                 i, evt_valid, evt_time, mq[0].tstamp);
      end
      apply_stimulus(1'b1, bit_vec(0), 1'b0, 1'b1);
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL change_drained: valid=%b required 0", evt_valid);
    end
  endtask

  task automatic test_overflow();
    logic [SW-1:0] s;
    logic [SW-1:0] prev;
    int pops;
    do_reset();
    prev = '0;
    for (int i = 0; i < 10; i++) begin
      s = rand_status() | bit_vec(i);
      if (s == prev) s[i+20] = ~s[i+20];
      apply_stimulus(1'b1, s, 1'b0, 1'b0);
      prev = s;
    end
    checks++;
    if (overflow !== 1'b1 || evt_count !== 4'd10) begin
      failures++;
      $display("[TB] FAIL ovf_fill: ovf=%b count=%0d required 1 10", overflow, evt_count);
    end
    pops = 0;
    while (evt_valid === 1'b1 && pops < 20) begin
      checks++;
      if (evt_status !== mq[0].status || evt_time !== mq[0].tstamp) begin
        failures++;
        $display("[TB] FAIL ovf_drain%0d: time=%0d required %0d", pops, evt_time, mq[0].tstamp);
      end
      apply_stimulus(1'b1, prev, 1'b0, 1'b1);
      pops++;
    end
    checks++;
    if (pops !== DEPTH || overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_entries: popped=%0d ovf=%b required %0d 1", pops, overflow, DEPTH);
    end
    // Full FIFO with a simultaneous pop must accept the event.
    do_reset();
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, bit_vec(i + 1), 1'b0, 1'b0);
    apply_stimulus(1'b1, bit_vec(50), 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0 || evt_count !== 4'd9 || evt_status !== bit_vec(2)) begin
      failures++;
      $display("[TB] FAIL full_pop_push: ovf=%b count=%0d required 0 9", overflow, evt_count);
    end
    // Empty FIFO: a read request alongside an event is ignored.
    do_reset();
    apply_stimulus(1'b1, bit_vec(9), 1'b0, 1'b1);
    checks++;
    if (evt_valid !== 1'b1 || evt_status !== bit_vec(9) || evt_time !== 32'd0) begin
      failures++;
      $display("[TB] FAIL empty_rd_push: valid=%b time=%0d required 1 0", evt_valid, evt_time);
    end
  endtask

  task automatic test_clear_collision();
    do_reset();
    apply_stimulus(1'b1, bit_vec(1), 1'b0, 1'b0);
    apply_stimulus(1'b1, bit_vec(2), 1'b0, 1'b0);
    apply_stimulus(1'b1, bit_vec(5), 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b0 || evt_count !== '0 || sticky_status !== '0 ||
        first_status !== '0 || first_time !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_zero: valid=%b count=%0d ovf=%b required all 0",
               evt_valid, evt_count, overflow);
    end
    checks++;
    if (dut.log_state !== CLEAN) begin
      failures++;
      $display("[TB] FAIL clear_state: got %0d required CLEAN", dut.log_state);
    end
    repeat (5) apply_stimulus(1'b1, bit_vec(5), 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b0 || evt_count !== '0 || irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_held: valid=%b count=%0d irq=%b required 0 0 0",
               evt_valid, evt_count, irq);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, bit_vec(10 + i), 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || irq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_setup: valid=%b irq=%b required 1 1", evt_valid, irq);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (evt_valid !== 1'b0 || evt_status !== '0 || evt_time !== '0 || first_status !== '0 ||
        sticky_status !== '0 || evt_count !== '0 || irq !== 1'b0 || dut.ts_q !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset: valid=%b count=%0d irq=%b ts=%0d required all 0",
               evt_valid, evt_count, irq, dut.ts_q);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (dut.ts_q !== 32'd1 || evt_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_restart: ts=%0d valid=%b required 1 0", dut.ts_q, evt_valid);
    end
  endtask

  task automatic test_random();
    logic [SW-1:0] pats [4];
    logic [SW-1:0] s;
    logic          a;
    logic          exp_valid;
    logic [SW-1:0] exp_status;
    logic [TW-1:0] exp_time;
    do_reset();
    for (int i = 0; i < 4; i++) pats[i] = rand_status();
    s = pats[0];
    for (int cyc = 0; cyc < 400; cyc++) begin
      a = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 4) s = pats[$urandom_range(0, 3)];
      apply_stimulus(a, s, ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0));
      exp_valid  = (mq.size() > 0);
      exp_status = exp_valid ? mq[0].status : '0;
      exp_time   = exp_valid ? mq[0].tstamp : '0;
      checks++;
      if (evt_valid !== exp_valid || evt_status !== exp_status || evt_time !== exp_time) begin
        failures++;
        $display("[TB] FAIL rand_head c%0d: valid=%b time=%0d required %b %0d",
                 cyc, evt_valid, evt_time, exp_valid, exp_time);
      end
      checks++;
      if (first_status !== m_first_s || first_time !== m_first_t || sticky_status !== m_sticky) begin
        failures++;
        $display("[TB] FAIL rand_summary c%0d: first_time=%0d required %0d",
                 cyc, first_time, m_first_t);
      end
      checks++;
      if (evt_count !== CNT_W'(m_count) || overflow !== m_ovf || irq !== m_irq) begin
        failures++;
        $display("[TB] FAIL rand_flags c%0d: count=%0d ovf=%b irq=%b required %0d %b %b",
                 cyc, evt_count, overflow, irq, m_count, m_ovf, m_irq);
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    pc_asserted = 1'b0;
    pc_status   = '0;
    clear       = 1'b0;
    evt_rd      = 1'b0;
    model_reset();
    test_reset();
    test_held_event();
    test_status_change();
    test_overflow();
    test_clear_collision();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
